// File: rtl/tl_sensor_cond.sv
// Conditions four asynchronous loop-detector lines into controller requests:
// two-flop synchronizer, debounce filter, release hold-stretch and arrival pulse.
module tl_sensor_cond #(
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_a,
  input  logic       raw_al,
  input  logic       raw_b,
  input  logic       raw_bl,
  output logic       Ta,
  output logic       Tal,
  output logic       Tb,
  output logic       Tbl,
  output logic [3:0] arr
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_1   = CNT_W'(1);

  logic [3:0]       raw_s;
  logic [3:0]       t_s;
  logic [3:0]       s1_q, s2_q;
  logic [3:0]       db_q, db_d;
  logic [3:0]       arr_q, arr_d;
  logic [CNT_W-1:0] dcnt_q [4];
  logic [CNT_W-1:0] dcnt_d [4];
  logic [CNT_W-1:0] hcnt_q [4];
  logic [CNT_W-1:0] hcnt_d [4];

  assign raw_s = {raw_bl, raw_b, raw_al, raw_a};

  // Request is high while debounced-high or while the release hold is running.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      t_s[i] = db_q[i] | (hcnt_q[i] != CNT_0);
    end
  end

  assign Ta  = t_s[0];
  assign Tal = t_s[1];
  assign Tb  = t_s[2];
  assign Tbl = t_s[3];
  assign arr = arr_q;

  // Per-channel next state: debounce, hold countdown and arrival detection.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]   = db_q[i];
      dcnt_d[i] = dcnt_q[i];
      hcnt_d[i] = hcnt_q[i];
      arr_d[i]  = 1'b0;

      if (s2_q[i] == db_q[i]) begin
        dcnt_d[i] = CNT_0;
      end else if (dcnt_q[i] == DB_LAST) begin
        db_d[i]   = s2_q[i];
        dcnt_d[i] = CNT_0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + CNT_1;
      end

      // A re-rise while the hold is still counting keeps T high and is not an arrival.
      if (db_q[i] && !db_d[i]) begin
        hcnt_d[i] = HOLD_V;
      end else if (db_q[i]) begin
        hcnt_d[i] = CNT_0;
      end else if (hcnt_q[i] != CNT_0) begin
        hcnt_d[i] = hcnt_q[i] - CNT_1;
      end else begin
        hcnt_d[i] = hcnt_q[i];
      end

      if (!db_q[i] && db_d[i] && !t_s[i]) begin
        arr_d[i] = 1'b1;
      end else begin
        arr_d[i] = 1'b0;
      end
    end
  end

  // State registers; asynchronous clear so outputs drop the moment reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 4'b0000;
      s2_q  <= 4'b0000;
      db_q  <= 4'b0000;
      arr_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        dcnt_q[i] <= CNT_0;
        hcnt_q[i] <= CNT_0;
      end
    end else begin
      s1_q  <= raw_s;
      s2_q  <= s1_q;
      db_q  <= db_d;
      arr_q <= arr_d;
      for (int i = 0; i < 4; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: default instance plus a DEBOUNCE=1/HOLD=0 instance,
// both compared every cycle against an event-time reference model.
module tb_tl_sensor_cond;

  localparam int DB0 = 4;
  localparam int HD0 = 8;
  localparam int DB1 = 1;
  localparam int HD1 = 0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] raw = 4'b0000;
  logic       ta0, tal0, tb0, tbl0, ta1, tal1, tb1, tbl1;
  logic [3:0] arr0, arr1;
  logic [3:0] t0, t1;

  int checks = 0;
  int failures = 0;

  int m_db   [2][4];
  int m_run  [2][4];
  int m_fall [2][4];
  int m_s1   [2][4];
  int m_s2   [2][4];
  int m_arr  [2][4];
  int edge_n = 0;

  always #5 clk = ~clk;

  assign t0 = {tbl0, tb0, tal0, ta0};
  assign t1 = {tbl1, tb1, tal1, ta1};

  tl_sensor_cond #(.DEBOUNCE(DB0), .HOLD(HD0), .CNT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .raw_a(raw[0]), .raw_al(raw[1]), .raw_b(raw[2]), .raw_bl(raw[3]),
    .Ta(ta0), .Tal(tal0), .Tb(tb0), .Tbl(tbl0), .arr(arr0)
  );

  tl_sensor_cond #(.DEBOUNCE(DB1), .HOLD(HD1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .raw_a(raw[0]), .raw_al(raw[1]), .raw_b(raw[2]), .raw_bl(raw[3]),
    .Ta(ta1), .Tal(tal1), .Tb(tb1), .Tbl(tbl1), .arr(arr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // T is high while debounced-high, or for HOLD edges counted from the falling edge.
  function automatic logic tm(input int k, input int c);
    int h;
    h = (k == 0) ? HD0 : HD1;
    return (m_db[k][c] != 0) || ((edge_n - m_fall[k][c]) < h);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        m_db[k][c] = 0; m_run[k][c] = 0; m_fall[k][c] = -100000;
        m_s1[k][c] = 0; m_s2[k][c] = 0; m_arr[k][c] = 0;
      end
    end
  endtask

  task automatic model_edge();
    int  d;
    int  odb;
    logic ot;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        d = (k == 0) ? DB0 : DB1;
        for (int c = 0; c < 4; c++) begin
          odb = m_db[k][c];
          ot  = tm(k, c);
          if (m_s2[k][c] != m_db[k][c]) begin
            m_run[k][c]++;
            if (m_run[k][c] == d) begin
              m_db[k][c]  = m_s2[k][c];
              m_run[k][c] = 0;
            end
          end else begin
            m_run[k][c] = 0;
          end
          if (odb != 0 && m_db[k][c] == 0) m_fall[k][c] = edge_n + 1;
          m_arr[k][c] = (odb == 0 && m_db[k][c] != 0 && !ot) ? 1 : 0;
          m_s2[k][c] = m_s1[k][c];
          m_s1[k][c] = int'(raw[c]);
        end
      end
    end
    edge_n++;
  endtask

  task automatic compare();
    logic [3:0] et, ea;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        et[c] = tm(k, c);
        ea[c] = (m_arr[k][c] != 0);
      end
      if (k == 0) begin
        chk("T_inst0", {28'd0, t0}, {28'd0, et});
        chk("arr_inst0", {28'd0, arr0}, {28'd0, ea});
      end else begin
        chk("T_inst1", {28'd0, t1}, {28'd0, et});
        chk("arr_inst1", {28'd0, arr1}, {28'd0, ea});
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Edge index (0-based from the next edge) at which the DUT output reaches lvl.
  task automatic meas(input int inst, input int ch, input logic lvl, input int maxc,
                      output int idx);
    logic [3:0] tv;
    idx = -1;
    for (int i = 0; i < maxc; i++) begin
      cycle();
      tv = (inst == 0) ? t0 : t1;
      if (tv[ch] == lvl) begin
        idx = i;
        break;
      end
    end
  endtask

  initial begin
    int idx;
    int seen;
    int pulses;
    model_reset();

    repeat (4) begin
      raw = 4'($urandom_range(0, 15));
      cycle();
      chk("rst_T0", {28'd0, t0}, 32'd0);
      chk("rst_arr0", {28'd0, arr0}, 32'd0);
    end
    raw = 4'b0000;
    reset_n = 1'b1;
    repeat (4) cycle();

    raw[0] = 1'b1;
    meas(0, 0, 1'b1, 30, idx);
    chk("press_latency", idx, 32'd5);
    chk("press_arr", {28'd0, arr0}, 32'd1);
    chk("press_others", {29'd0, t0[3:1]}, 32'd0);
    cycle();
    chk("press_arr_once", {28'd0, arr0}, 32'd0);
    repeat (15) cycle();

    raw[0] = 1'b0;
    meas(0, 0, 1'b0, 40, idx);
    chk("release_latency", idx, 32'd13);

    raw[2] = 1'b1;
    repeat (3) cycle();
    raw[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (tb0 || arr0[2]) seen = 1;
    end
    chk("glitch_reject", seen, 32'd0);

    idx = -1;
    raw[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) raw[2] = 1'b0;
      cycle();
      if (tb0 && idx < 0) idx = i;
    end
    chk("glitch4_accept", idx, 32'd5);
    repeat (20) cycle();

    raw[1] = 1'b1;
    repeat (10) cycle();
    raw[1] = 1'b0;
    seen = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 8) raw[1] = 1'b1;
      if (i == 18) raw[1] = 1'b0;
      cycle();
      if (!tal0) seen++;
      if (arr0[1]) pulses++;
    end
    chk("repress_no_drop", seen, 32'd0);
    chk("repress_no_arr", pulses, 32'd0);
    repeat (40) cycle();

    for (int r = 0; r < 2; r++) begin
      raw[3] = 1'b1;
      meas(1, 3, 1'b1, 10, idx);
      chk("corner_rise", idx, 32'd2);
      chk("corner_arr", {28'd0, arr1}, 32'h8);
      repeat (r + 2) cycle();
      raw[3] = 1'b0;
      meas(1, 3, 1'b0, 10, idx);
      chk("corner_fall", idx, 32'd2);
      repeat (2) cycle();
    end
    repeat (25) cycle();

    raw = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 4) chk("conc_T_before", {28'd0, t0}, 32'd0);
      if (i == 5) begin
        chk("conc_T", {28'd0, t0}, 32'hF);
        chk("conc_arr", {28'd0, arr0}, 32'hF);
      end
      if (i == 6) chk("conc_arr_once", {28'd0, arr0}, 32'd0);
    end
    raw = 4'b0000;
    repeat (30) cycle();

    raw[0] = 1'b1;
    repeat (10) cycle();
    raw[0] = 1'b0;
    repeat (8) cycle();
    chk("hold_pre_reset", {31'd0, ta0}, 32'd1);
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("async_rst_T0", {28'd0, t0}, 32'd0);
    chk("async_rst_arr0", {28'd0, arr0}, 32'd0);
    chk("async_rst_T1", {28'd0, t1}, 32'd0);
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (3) cycle();

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
      end
      cycle();
    end
    raw = 4'b0000;
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
